// File: rtl/kcpsmx_scratch_banked.sv
`default_nettype none
// ============================================================================
// kcpsmx_scratch_banked : banked scratchpad RAM with auxiliary port and clear
// Revision 1.0
// ============================================================================
module kcpsmx_scratch_banked #(
  parameter int SCRATCH_WIDTH  = 8,
  parameter int SCRATCH_DEPTH  = 6,
  parameter int NUM_BANKS      = 4,
  parameter int CLEAR_ON_RESET = 1,
  localparam int BANK_BITS     = $clog2(NUM_BANKS)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [SCRATCH_DEPTH-1:0]           address,
  input  logic                               write_enable,
  input  logic [SCRATCH_WIDTH-1:0]           data_in,
  output logic [SCRATCH_WIDTH-1:0]           data_out,
  input  logic                               bank_load,
  input  logic [BANK_BITS-1:0]               bank_in,
  output logic [BANK_BITS-1:0]               bank_out,
  input  logic                               aux_req,
  input  logic                               aux_we,
  input  logic [BANK_BITS+SCRATCH_DEPTH-1:0] aux_addr,
  input  logic [SCRATCH_WIDTH-1:0]           aux_wdata,
  output logic                               aux_ack,
  output logic [SCRATCH_WIDTH-1:0]           aux_rdata,
  output logic                               busy
);

  localparam int ADDR_W = BANK_BITS + SCRATCH_DEPTH;
  localparam int TOTAL  = NUM_BANKS * (2 ** SCRATCH_DEPTH);
  localparam logic [ADDR_W-1:0] c_PTR_LAST = ADDR_W'(TOTAL - 1);
  localparam logic [ADDR_W-1:0] c_PTR_ONE  = ADDR_W'(1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_e;

  localparam state_e c_RESET_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;

  state_e                   state_q, state_d;
  logic [ADDR_W-1:0]        ptr_q, ptr_d;
  logic [BANK_BITS-1:0]     bank_q;
  logic                     aux_ack_q;
  logic [SCRATCH_WIDTH-1:0] aux_rdata_q;
  logic [SCRATCH_WIDTH-1:0] mem_q [TOTAL];

  logic              busy_w;
  logic              aux_accept_w;
  logic [ADDR_W-1:0] proc_addr_w;

  assign busy_w       = (state_q == S_CLEAR);
  assign aux_accept_w = aux_req & ~busy_w;
  assign proc_addr_w  = {bank_q, address};

  // Clear sequencer
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= c_RESET_STATE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_CLEAR: begin
        if (ptr_q == c_PTR_LAST) begin
          state_d = S_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + c_PTR_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Bank register and auxiliary response path
  always_ff @(posedge clk) begin
    if (reset) begin
      bank_q      <= '0;
      aux_ack_q   <= 1'b0;
      aux_rdata_q <= '0;
    end else begin
      aux_ack_q <= aux_accept_w;
      if (aux_accept_w && !aux_we) begin
        aux_rdata_q <= mem_q[aux_addr];
      end
      if (bank_load && !busy_w) begin
        bank_q <= bank_in;
      end
    end
  end

  // Processor write is issued after the aux write so it wins on a collision
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (busy_w) begin
        mem_q[ptr_q] <= '0;
      end else begin
        if (aux_accept_w && aux_we) begin
          mem_q[aux_addr] <= aux_wdata;
        end
        if (write_enable) begin
          mem_q[proc_addr_w] <= data_in;
        end
      end
    end
  end

  assign data_out  = busy_w ? '0 : mem_q[proc_addr_w];
  assign bank_out  = bank_q;
  assign aux_ack   = aux_ack_q;
  assign aux_rdata = aux_rdata_q;
  assign busy      = busy_w;

endmodule

`default_nettype wire

// File: tb/tb_kcpsmx_scratch_banked.sv
`default_nettype none
// ============================================================================
// tb_kcpsmx_scratch_banked : directed + random bench against a flat-array model
// Revision 1.0
// ============================================================================
module tb_kcpsmx_scratch_banked;

  logic       clk;
  logic       reset, write_enable, bank_load, aux_req, aux_we;
  logic [5:0] address;
  logic [7:0] data_in, aux_wdata, data_out, aux_rdata;
  logic [1:0] bank_in, bank_out;
  logic [7:0] aux_addr;
  logic       aux_ack, busy;

  logic       b_reset, b_write_enable, b_bank_load, b_aux_req, b_aux_we;
  logic [5:0] b_address;
  logic [7:0] b_data_in, b_aux_wdata, b_data_out, b_aux_rdata;
  logic [1:0] b_bank_in, b_bank_out;
  logic [7:0] b_aux_addr;
  logic       b_aux_ack, b_busy;

  kcpsmx_scratch_banked dut (
    .clk(clk), .reset(reset), .address(address), .write_enable(write_enable),
    .data_in(data_in), .data_out(data_out), .bank_load(bank_load),
    .bank_in(bank_in), .bank_out(bank_out), .aux_req(aux_req), .aux_we(aux_we),
    .aux_addr(aux_addr), .aux_wdata(aux_wdata), .aux_ack(aux_ack),
    .aux_rdata(aux_rdata), .busy(busy)
  );

  kcpsmx_scratch_banked #(.CLEAR_ON_RESET(0)) dut_nc (
    .clk(clk), .reset(b_reset), .address(b_address), .write_enable(b_write_enable),
    .data_in(b_data_in), .data_out(b_data_out), .bank_load(b_bank_load),
    .bank_in(b_bank_in), .bank_out(b_bank_out), .aux_req(b_aux_req), .aux_we(b_aux_we),
    .aux_addr(b_aux_addr), .aux_wdata(b_aux_wdata), .aux_ack(b_aux_ack),
    .aux_rdata(b_aux_rdata), .busy(b_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: flat word array plus a count of remaining clear cycles
  logic [7:0] mem_m [256];
  int         clr_left;
  logic [1:0] bank_m;
  logic       ack_m;
  logic [7:0] rdata_m;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    reset = 1'b0; write_enable = 1'b0; bank_load = 1'b0; aux_req = 1'b0; aux_we = 1'b0;
    address = '0; data_in = '0; bank_in = '0; aux_addr = '0; aux_wdata = '0;
  endtask

  // Advance the model by one edge from the current inputs, clock, then compare
  task automatic cyc();
    if (reset) begin
      bank_m = '0; ack_m = 1'b0; rdata_m = '0; clr_left = 256;
      for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;
    end else if (clr_left > 0) begin
      clr_left--;
      ack_m = 1'b0;
    end else begin
      ack_m = aux_req;
      if (aux_req && !aux_we) rdata_m = mem_m[aux_addr];
      if (aux_req && aux_we) mem_m[aux_addr] = aux_wdata;
      if (write_enable) mem_m[{bank_m, address}] = data_in;
      if (bank_load) bank_m = bank_in;
    end
    @(posedge clk); #1;
    chk("busy", 32'(busy), 32'(clr_left > 0));
    chk("aux_ack", 32'(aux_ack), 32'(ack_m));
    chk("aux_rdata", 32'(aux_rdata), 32'(rdata_m));
    chk("bank_out", 32'(bank_out), 32'(bank_m));
  endtask

  task automatic chk_dout(input string tag);
    logic [7:0] e;
    #1;
    e = (clr_left > 0) ? 8'h00 : mem_m[{bank_m, address}];
    chk(tag, 32'(data_out), 32'(e));
  endtask

  task automatic count_busy(input string tag);
    int n;
    n = (busy === 1'b1) ? 1 : 0;
    while (busy === 1'b1 && n < 400) begin
      aux_addr = 8'($urandom);
      cyc();
      if (busy === 1'b1) n++;
    end
    chk(tag, 32'(n), 32'd256);
  endtask

  initial begin
    idle();
    b_reset = 1'b0; b_write_enable = 1'b0; b_bank_load = 1'b0; b_aux_req = 1'b0;
    b_aux_we = 1'b0; b_address = '0; b_data_in = '0; b_bank_in = '0;
    b_aux_addr = '0; b_aux_wdata = '0;

    // Power-up reset and full clear; aux requests during busy are dropped
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk_dout("dout_during_clear");
    aux_req = 1'b1;
    count_busy("clear_len");
    aux_req = 1'b0;

    for (int i = 0; i < 256; i++) begin
      aux_req = 1'b1; aux_we = 1'b0; aux_addr = 8'(i);
      cyc();
    end
    idle();
    cyc();

    // Banked write, then flat aux read of the same word
    bank_load = 1'b1; bank_in = 2'd2;
    cyc();
    bank_load = 1'b0; address = 6'h05; write_enable = 1'b1; data_in = 8'hA5;
    cyc();
    write_enable = 1'b0; bank_load = 1'b1; bank_in = 2'd0;
    cyc();
    bank_load = 1'b0; aux_req = 1'b1; aux_we = 1'b0; aux_addr = 8'h85;
    cyc();
    idle();
    address = 6'h05;
    chk_dout("bank0_dout");
    chk("bank2_aux_rdata", 32'(aux_rdata), 32'h0000_00A5);
    chk("bank0_word5_zero", 32'(data_out), 32'h0);

    // Same-cycle processor and aux write to one word
    address = 6'h0A; write_enable = 1'b1; data_in = 8'h11;
    aux_req = 1'b1; aux_we = 1'b1; aux_addr = 8'h0A; aux_wdata = 8'h22;
    cyc();
    chk("collide_ack_hi", 32'(aux_ack), 32'd1);
    idle();
    cyc();
    chk("collide_ack_lo", 32'(aux_ack), 32'd0);
    address = 6'h0A;
    #1;
    chk("collide_proc_wins", 32'(data_out), 32'h11);

    // Back-to-back aux reads
    for (int i = 0; i < 3; i++) begin
      address = 6'(8'h10 + i); write_enable = 1'b1; data_in = 8'(8'h30 + i);
      cyc();
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      aux_req = 1'b1; aux_we = 1'b0; aux_addr = 8'(8'h10 + i);
      cyc();
      chk("pipe_ack", 32'(aux_ack), 32'd1);
      chk("pipe_data", 32'(aux_rdata), 32'(8'h30 + i));
    end
    idle();
    cyc();
    chk("pipe_ack_end", 32'(aux_ack), 32'd0);

    // Random traffic on a narrow window so collisions are frequent
    for (int i = 0; i < 400; i++) begin
      write_enable = 1'($urandom);
      address      = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'($urandom_range(0, 3));
      data_in      = 8'($urandom);
      bank_load    = ($urandom_range(0, 3) == 0);
      bank_in      = 2'($urandom);
      aux_req      = 1'($urandom);
      aux_we       = 1'($urandom);
      aux_addr     = {2'($urandom), 6'($urandom_range(0, 3))};
      aux_wdata    = 8'($urandom);
      chk_dout("rnd_dout");
      cyc();
    end
    idle();

    // Reset coinciding with an aux request cancels its ack; restart mid-clear
    reset = 1'b1; aux_req = 1'b1;
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 99; i++) begin
      aux_addr = 8'($urandom);
      cyc();
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    count_busy("restart_clear_len");
    idle();
    for (int i = 0; i < 4; i++) begin
      address = 6'($urandom);
      chk_dout("post_clear_dout");
    end
    aux_req = 1'b1; aux_addr = 8'h85;
    cyc();
    idle();
    chk("post_clear_aux", 32'(aux_rdata), 32'h0);

    // Instance without clear: contents survive reset
    b_reset = 1'b1;
    @(posedge clk); #1;
    b_reset = 1'b0; b_bank_load = 1'b1; b_bank_in = 2'd3;
    @(posedge clk); #1;
    b_bank_load = 1'b0; b_address = 6'h3F; b_write_enable = 1'b1; b_data_in = 8'h3C;
    @(posedge clk); #1;
    b_write_enable = 1'b0;
    chk("nc_bank3", 32'(b_bank_out), 32'd3);
    b_reset = 1'b1;
    @(posedge clk); #1;
    b_reset = 1'b0;
    chk("nc_busy", 32'(b_busy), 32'd0);
    chk("nc_bank0", 32'(b_bank_out), 32'd0);
    chk("nc_rdata_rst", 32'(b_aux_rdata), 32'd0);
    b_aux_req = 1'b1; b_aux_we = 1'b0; b_aux_addr = 8'hFF;
    @(posedge clk); #1;
    b_aux_req = 1'b0;
    chk("nc_ack", 32'(b_aux_ack), 32'd1);
    chk("nc_keep", 32'(b_aux_rdata), 32'h3C);
    @(posedge clk); #1;
    chk("nc_ack_lo", 32'(b_aux_ack), 32'd0);
    chk("nc_busy_end", 32'(b_busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
